program_counter: RTL
====================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, return-address stack depth in entries (2..16).
REQ-002 SHALL have parameter RESET_ADDR, default 16'h0000, PC value after reset.
REQ-003 SHALL have clock and reset as follows: one clock; reset is synchronous and active-high.
REQ-004 SHALL have port CLK  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port CLR  input  1  synchronous active-high reset.
REQ-006 SHALL have port WBUS  input  16  jump/call target from the W bus.
REQ-007 SHALL have port Cp  input  1  increment PC (1 = increment).
REQ-008 SHALL have port nLp  input  1  load PC from WBUS (0 = load).
REQ-009 SHALL have port nCall  input  1  push return address, then load WBUS (0 = call).
REQ-010 SHALL have port nRet  input  1  pop return address into PC (0 = return).
REQ-011 SHALL have port Ep  input  1  drive PC onto bus output (1 = enable).
REQ-012 SHALL have port pc_out  output  16  registered PC value, always driven.
REQ-013 SHALL have port WBUS_out  output  16  PC when Ep=1, else 16'hZZZZ.
REQ-014 SHALL have port stack_empty  output  1  high when stack holds 0 entries.
REQ-015 SHALL have port stack_full  output  1  high when stack holds DEPTH entries.
REQ-016 SHALL have port stack_err  output  1  sticky overflow/underflow flag.

Function
REQ-017 SHALL apply exactly one operation per cycle, priority CLR > nRet > nCall > nLp > Cp; lower-priority requests in the same cycle are ignored.
REQ-018 SHALL, on Cp=1 alone, set PC to PC+1 modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag).
REQ-019 SHALL, on nLp=0, set PC to WBUS at the next edge; new value visible on pc_out one cycle later.
REQ-020 SHALL, on nCall=0 with stack not full, push current PC and load PC from WBUS in the same edge.
REQ-021 SHALL, on nCall=0 with stack full, still load PC from WBUS, drop the push, keep contents unchanged, set stack_err.
REQ-022 SHALL, on nRet=0 with stack not empty, load PC with top entry and pop it in the same edge.
REQ-023 SHALL, on nRet=0 with stack empty, leave PC unchanged and set stack_err.
REQ-024 SHALL order the stack LIFO; the entry popped is the most recent unpopped push.
REQ-025 SHALL hold PC when no operation is requested.
REQ-026 SHALL derive stack_empty/stack_full combinationally from the registered entry count; both update the cycle after a push/pop.
REQ-027 SHALL make WBUS_out combinational from Ep and registered PC; Ep has no effect on state.
REQ-028 SHALL keep stack_err set until CLR.

Reset
REQ-029 SHALL, when CLR=1 at an edge, set PC to RESET_ADDR, entry count to 0 and stack_err to 0, overriding all other inputs.
REQ-030 SHALL, after reset, give pc_out=RESET_ADDR, stack_empty=1, stack_full=0, stack_err=0; stack storage contents are don't-care.
REQ-031 SHALL treat CLR asserted mid-call or mid-return as a full reset; the pending operation is discarded.

Structure
REQ-032 SHALL take the 16-bit address width and the default RESET_ADDR from the shared SAP-II definitions include file.
REQ-033 SHALL implement the return stack as one sub-module, pc_stack, with push/pop/data/count interface, parameterised by DEPTH.
REQ-034 SHALL keep PC register, priority decode and bus driver in program_counter.

Verification
REQ-035 SHALL verify: CLR=1 then Cp=1 for 3 cycles -> pc_out 0000, 0001, 0002, 0003; Ep=0 -> WBUS_out=ZZZZ.
REQ-036 SHALL verify: nLp=0, WBUS=16'hFFFF, then Cp=1 -> pc_out FFFF then 0000, stack_err=0.
REQ-037 SHALL verify: PC=0010, nCall=0 WBUS=2000; then nRet=0 -> pc_out 2000, then 0010; stack_empty 0 then 1.
REQ-038 SHALL verify: 5 calls with DEPTH=4 (targets 1000..5000) -> stack_full=1 after 4th, stack_err=1 after 5th, pc_out=5000; 4 returns yield the 4 pushed addresses in reverse order.
REQ-039 SHALL verify: nRet=0 on empty stack at PC=0042 -> pc_out stays 0042, stack_err=1 until CLR.
REQ-040 SHALL verify: nRet=0, nCall=0, nLp=0, Cp=1 together with one entry 0300 stacked -> pc_out=0300, stack_empty=1; CLR in same cycle instead -> pc_out=RESET_ADDR.

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared SAP-II definitions for the program counter slice: address width,
// default reset vector and the one-operation-per-cycle priority decode.
package program_counter_pkg;

  localparam int ADDR_W = 16;
  localparam logic [ADDR_W-1:0] SAP_RESET_ADDR = 16'h0000;

  typedef enum logic [2:0] {
    OP_NONE,
    OP_RET,
    OP_CALL,
    OP_LOAD,
    OP_INC
  } pc_op_e;

  // Return beats call beats load beats increment; controls are active-low except Cp.
  function automatic pc_op_e decode_op(input logic nret, input logic ncall,
                                       input logic nlp, input logic cp);
    pc_op_e op;
    op = OP_NONE;
    if (!nret)       op = OP_RET;
    else if (!ncall) op = OP_CALL;
    else if (!nlp)   op = OP_LOAD;
    else if (cp)     op = OP_INC;
    return op;
  endfunction

endpackage

// File: rtl/program_counter_stack.sv
// Return-address LIFO for the program counter. Only the entry count is reset;
// storage is left as-is because it is unreadable until pushed again.
module pc_stack
  import program_counter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push_i,
  input  logic                           pop_i,
  input  logic [ADDR_W-1:0]              data_i,
  output logic [ADDR_W-1:0]              top_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;
  logic [CW-1:0]     top_cnt;
  logic              do_push;
  logic              do_pop;

  assign do_push = push_i && (cnt_q != CW'(DEPTH));
  assign do_pop  = pop_i && !push_i && (cnt_q != '0);
  assign top_cnt = cnt_q - CW'(1);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push)     cnt_d = cnt_q + CW'(1);
    else if (do_pop) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Next free slot is indexed by the current count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst && do_push && cnt_q == CW'(i)) mem_q[i] <= data_i;
    end
  end

  always_comb begin
    top_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (top_cnt == CW'(i)) top_o = mem_q[i];
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/program_counter.sv
// SAP-II program counter: PC register with increment/load/call/return, a
// sticky stack error flag, and a tri-state bus driver gated by Ep.
module program_counter
  import program_counter_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = SAP_RESET_ADDR
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] WBUS,
  input  logic              Cp,
  input  logic              nLp,
  input  logic              nCall,
  input  logic              nRet,
  input  logic              Ep,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] WBUS_out,
  output logic              stack_empty,
  output logic              stack_full,
  output logic              stack_err
);

  localparam int CW = $clog2(DEPTH + 1);

  pc_op_e            op;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              err_q;
  logic              err_d;
  logic [ADDR_W-1:0] stk_top;
  logic [CW-1:0]     stk_cnt;
  logic              stk_push;
  logic              stk_pop;

  assign op          = decode_op(nRet, nCall, nLp, Cp);
  assign stack_empty = (stk_cnt == '0);
  assign stack_full  = (stk_cnt == CW'(DEPTH));

  assign stk_push = !CLR && (op == OP_CALL) && !stack_full;
  assign stk_pop  = !CLR && (op == OP_RET) && !stack_empty;

  always_comb begin
    pc_d  = pc_q;
    err_d = err_q;
    case (op)
      OP_RET: begin
        if (stack_empty) err_d = 1'b1;
        else             pc_d  = stk_top;
      end
      OP_CALL: begin
        pc_d = WBUS;
        if (stack_full) err_d = 1'b1;
      end
      OP_LOAD: pc_d = WBUS;
      OP_INC:  pc_d = pc_q + ADDR_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      pc_q  <= RESET_ADDR;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  pc_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk     (CLK),
    .rst     (CLR),
    .push_i  (stk_push),
    .pop_i   (stk_pop),
    .data_i  (pc_q),
    .top_o   (stk_top),
    .count_o (stk_cnt)
  );

  assign pc_out    = pc_q;
  assign stack_err = err_q;
  assign WBUS_out  = Ep ? pc_q : 16'hzzzz;

endmodule
